// File: rtl/jtag_frame_loader.sv
// jtag_frame_loader: decodes the byte stream from the JTAG CDC front end and
// writes little-endian words into one of CHANNELS memories.
//
// Ports:
//   clk_i, rst_i         system clock, asynchronous active-high reset
//   abort_i              synchronous abort, returns to idle and clears state
//   in_valid_i/in_data_i incoming byte stream; in_ready_o low only in StWrite
//   we_o                 one-hot write strobe (one cycle per word)
//   write_addr_o, data_o address and word for the current write
//   busy_o               high whenever a frame is in progress
//   err_o                sticky protocol error (bad command or channel)
//   word_cnt_o           words written since reset/abort, wraps at 2^16
//
// Protocol (command bytes accepted in idle):
//   0x01 SET_ADDR + ceil(ADDR_WIDTH/8) address bytes, LSB first
//   0x02 SELECT   + channel index byte
//   0x03 WRITE    + count byte (0 = 256) + count * DATA_WIDTH/8 data bytes
module jtag_frame_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CHANNELS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  abort_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic [CHANNELS-1:0]   we_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           word_cnt_o
);

  localparam int unsigned WB = DATA_WIDTH / 8;
  localparam int unsigned AB = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StChan,
    StCount,
    StData,
    StWrite
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AB*8-1:0]       addr_acc_q, addr_acc_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [15:0]           wcnt_q, wcnt_d;

  logic                  accept;
  logic [AB*8-1:0]       addr_full;
  logic [DATA_WIDTH-1:0] word_full;

  // No byte is taken during the one-cycle write strobe.
  assign accept = in_valid_i && (state_q != StWrite);

  // Partial values with the incoming byte merged at the current byte index.
  always_comb begin
    addr_full = addr_acc_q;
    for (int b = 0; b < int'(AB); b++) begin
      if (idx_q == 3'(b)) addr_full[b*8 +: 8] = in_data_i;
    end
    word_full = asm_q;
    for (int b = 0; b < int'(WB); b++) begin
      if (idx_q == 3'(b)) word_full[b*8 +: 8] = in_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_acc_d = addr_acc_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    data_d     = data_q;
    err_d      = err_q;
    wcnt_d     = wcnt_q;

    if (abort_i) begin
      // data_d keeps the last written word.
      state_d    = StIdle;
      addr_d     = '0;
      addr_acc_d = '0;
      chan_d     = '0;
      cnt_d      = '0;
      idx_d      = '0;
      asm_d      = '0;
      err_d      = 1'b0;
      wcnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_d = '0;
            case (in_data_i)
              8'h01:   state_d = StAddr;
              8'h02:   state_d = StChan;
              8'h03:   state_d = StCount;
              default: err_d = 1'b1;
            endcase
          end
        end
        StAddr: begin
          if (accept) begin
            if (idx_q == 3'(AB - 1)) begin
              addr_d     = addr_full[ADDR_WIDTH-1:0];
              addr_acc_d = '0;
              idx_d      = '0;
              state_d    = StIdle;
            end else begin
              addr_acc_d = addr_full;
              idx_d      = idx_q + 3'd1;
            end
          end
        end
        StChan: begin
          if (accept) begin
            if (32'(in_data_i) < CHANNELS) chan_d = in_data_i[CW-1:0];
            else err_d = 1'b1;
            state_d = StIdle;
          end
        end
        StCount: begin
          if (accept) begin
            cnt_d   = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
            idx_d   = '0;
            state_d = StData;
          end
        end
        StData: begin
          if (accept) begin
            if (idx_q == 3'(WB - 1)) begin
              data_d  = word_full;
              asm_d   = '0;
              idx_d   = '0;
              state_d = StWrite;
            end else begin
              asm_d = word_full;
              idx_d = idx_q + 3'd1;
            end
          end
        end
        StWrite: begin
          // Strobe is visible this cycle; address/count advance afterwards.
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wcnt_d  = wcnt_q + 16'd1;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? StIdle : StData;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      addr_acc_q <= '0;
      chan_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_acc_q <= addr_acc_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      err_q      <= err_d;
      wcnt_q     <= wcnt_d;
    end
  end

  always_comb begin
    we_o = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      we_o[c] = (state_q == StWrite) && (chan_q == CW'(c));
    end
  end

  assign in_ready_o   = (state_q != StWrite);
  assign busy_o       = (state_q != StIdle);
  assign write_addr_o = addr_q;
  assign data_o       = data_q;
  assign err_o        = err_q;
  assign word_cnt_o   = wcnt_q;

endmodule

// File: tb/tb_jtag_frame_loader.sv
// Directed bench for jtag_frame_loader (DATA_WIDTH=32, ADDR_WIDTH=10, CHANNELS=2).
// Per-cycle vector table plus hand-written stream and async-reset sequences.
module tb_jtag_frame_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        abort_i;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic [1:0]  we_o;
  logic [9:0]  write_addr_o;
  logic [31:0] data_o;
  logic        busy_o;
  logic        err_o;
  logic [15:0] word_cnt_o;

  jtag_frame_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .CHANNELS  (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .we_o        (we_o),
    .write_addr_o(write_addr_o),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        a;
    logic [1:0]  we;
    logic [9:0]  addr;
    logic [31:0] dat;
    logic        busy;
    logic        err;
    logic        rdy;
    logic [15:0] wc;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  strm[0:13];
  int          idx;
  int          nw;
  int          lowc;
  logic        acc;

  task automatic add(input logic v, input logic [7:0] d, input logic a,
                     input logic [1:0] we, input logic [9:0] addr, input logic [31:0] dat,
                     input logic busy, input logic err, input logic rdy,
                     input logic [15:0] wc);
    vec_t t;
    t.v = v; t.d = d; t.a = a; t.we = we; t.addr = addr; t.dat = dat;
    t.busy = busy; t.err = err; t.rdy = rdy; t.wc = wc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Packed as {we, addr, data, busy, err, ready, word_cnt}
  function automatic logic [62:0] outs();
    return {we_o, write_addr_o, data_o, busy_o, err_o, in_ready_o, word_cnt_o};
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic a);
    in_valid_i = v;
    in_data_i  = d;
    abort_i    = a;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Scenario 1: SET_ADDR 5, WRITE 2 words on channel 0, valid held high.
    add(1, 8'h01, 0, 2'b00, 10'h000, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h05, 0, 2'b00, 10'h000, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h00, 0, 2'b00, 10'h005, 32'h0,        0, 0, 1, 16'd0);
    add(1, 8'h03, 0, 2'b00, 10'h005, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h02, 0, 2'b00, 10'h005, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h11, 0, 2'b00, 10'h005, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h22, 0, 2'b00, 10'h005, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h33, 0, 2'b00, 10'h005, 32'h0,        1, 0, 1, 16'd0);
    add(1, 8'h44, 0, 2'b01, 10'h005, 32'h44332211, 1, 0, 0, 16'd0);
    add(1, 8'hAA, 0, 2'b00, 10'h006, 32'h44332211, 1, 0, 1, 16'd1);  // not taken
    add(1, 8'hAA, 0, 2'b00, 10'h006, 32'h44332211, 1, 0, 1, 16'd1);
    add(1, 8'hBB, 0, 2'b00, 10'h006, 32'h44332211, 1, 0, 1, 16'd1);
    add(1, 8'hCC, 0, 2'b00, 10'h006, 32'h44332211, 1, 0, 1, 16'd1);
    add(1, 8'hDD, 0, 2'b01, 10'h006, 32'hDDCCBBAA, 1, 0, 0, 16'd1);
    add(0, 8'h00, 0, 2'b00, 10'h007, 32'hDDCCBBAA, 0, 0, 1, 16'd2);
    // Scenario 2: channel 1, address 0x3FF, two words wrapping to 0.
    add(1, 8'h02, 0, 2'b00, 10'h007, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h01, 0, 2'b00, 10'h007, 32'hDDCCBBAA, 0, 0, 1, 16'd2);
    add(1, 8'h01, 0, 2'b00, 10'h007, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'hFF, 0, 2'b00, 10'h007, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h03, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 0, 0, 1, 16'd2);
    add(1, 8'h03, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h02, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h01, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h02, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h03, 0, 2'b00, 10'h3FF, 32'hDDCCBBAA, 1, 0, 1, 16'd2);
    add(1, 8'h04, 0, 2'b10, 10'h3FF, 32'h04030201, 1, 0, 0, 16'd2);
    add(0, 8'h00, 0, 2'b00, 10'h000, 32'h04030201, 1, 0, 1, 16'd3);
    add(1, 8'h05, 0, 2'b00, 10'h000, 32'h04030201, 1, 0, 1, 16'd3);
    add(1, 8'h06, 0, 2'b00, 10'h000, 32'h04030201, 1, 0, 1, 16'd3);
    add(1, 8'h07, 0, 2'b00, 10'h000, 32'h04030201, 1, 0, 1, 16'd3);
    add(1, 8'h08, 0, 2'b10, 10'h000, 32'h08070605, 1, 0, 0, 16'd3);
    add(0, 8'h00, 0, 2'b00, 10'h001, 32'h08070605, 0, 0, 1, 16'd4);
    // Abort after 2 of 4 data bytes, then a clean frame at address 0.
    add(1, 8'h03, 0, 2'b00, 10'h001, 32'h08070605, 1, 0, 1, 16'd4);
    add(1, 8'h01, 0, 2'b00, 10'h001, 32'h08070605, 1, 0, 1, 16'd4);
    add(1, 8'h11, 0, 2'b00, 10'h001, 32'h08070605, 1, 0, 1, 16'd4);
    add(1, 8'h22, 0, 2'b00, 10'h001, 32'h08070605, 1, 0, 1, 16'd4);
    add(1, 8'h33, 1, 2'b00, 10'h000, 32'h08070605, 0, 0, 1, 16'd0);
    add(0, 8'h00, 0, 2'b00, 10'h000, 32'h08070605, 0, 0, 1, 16'd0);
    add(1, 8'h03, 0, 2'b00, 10'h000, 32'h08070605, 1, 0, 1, 16'd0);
    add(1, 8'h01, 0, 2'b00, 10'h000, 32'h08070605, 1, 0, 1, 16'd0);
    add(1, 8'h55, 0, 2'b00, 10'h000, 32'h08070605, 1, 0, 1, 16'd0);
    add(1, 8'h66, 0, 2'b00, 10'h000, 32'h08070605, 1, 0, 1, 16'd0);
    add(1, 8'h77, 0, 2'b00, 10'h000, 32'h08070605, 1, 0, 1, 16'd0);
    add(1, 8'h88, 0, 2'b01, 10'h000, 32'h88776655, 1, 0, 0, 16'd0);
    add(0, 8'h00, 0, 2'b00, 10'h001, 32'h88776655, 0, 0, 1, 16'd1);
    // Bad channel then bad command: sticky error, channel stays 0.
    add(1, 8'h02, 0, 2'b00, 10'h001, 32'h88776655, 1, 0, 1, 16'd1);
    add(1, 8'h05, 0, 2'b00, 10'h001, 32'h88776655, 0, 1, 1, 16'd1);
    add(1, 8'h07, 0, 2'b00, 10'h001, 32'h88776655, 0, 1, 1, 16'd1);
    add(1, 8'h03, 0, 2'b00, 10'h001, 32'h88776655, 1, 1, 1, 16'd1);
    add(1, 8'h01, 0, 2'b00, 10'h001, 32'h88776655, 1, 1, 1, 16'd1);
    add(1, 8'h9A, 0, 2'b00, 10'h001, 32'h88776655, 1, 1, 1, 16'd1);
    add(1, 8'hBC, 0, 2'b00, 10'h001, 32'h88776655, 1, 1, 1, 16'd1);
    add(1, 8'hDE, 0, 2'b00, 10'h001, 32'h88776655, 1, 1, 1, 16'd1);
    add(1, 8'hF0, 0, 2'b01, 10'h001, 32'hF0DEBC9A, 1, 1, 0, 16'd1);
    add(0, 8'h00, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 0, 1, 1, 16'd2);
    // Abort during the strobe cycle: strobe stands, then everything clears.
    add(1, 8'h03, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 1, 1, 1, 16'd2);
    add(1, 8'h01, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 1, 1, 1, 16'd2);
    add(1, 8'h01, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 1, 1, 1, 16'd2);
    add(1, 8'h02, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 1, 1, 1, 16'd2);
    add(1, 8'h03, 0, 2'b00, 10'h002, 32'hF0DEBC9A, 1, 1, 1, 16'd2);
    add(1, 8'h04, 0, 2'b01, 10'h002, 32'h04030201, 1, 1, 0, 16'd2);
    add(0, 8'h00, 1, 2'b00, 10'h000, 32'h04030201, 0, 0, 1, 16'd0);

    rst_i      = 1'b1;
    abort_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_state", 64'(outs()), 64'({2'b00, 10'h000, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0}));

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].a);
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].busy, vecs[i].err,
               vecs[i].rdy, vecs[i].wc}));
    end

    // Continuous 3-word stream on channel 0 from address 0.
    strm[0] = 8'h03;
    strm[1] = 8'h03;
    for (int i = 0; i < 12; i++) strm[2+i] = 8'h10 + 8'(i);
    idx  = 0;
    nw   = 0;
    lowc = 0;
    for (int cyc = 0; cyc < 60 && idx < 14; cyc++) begin
      in_valid_i = 1'b1;
      in_data_i  = strm[idx];
      abort_i    = 1'b0;
      acc        = in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) idx++;
      if (!in_ready_o) lowc++;
      chk("strm_ready_vs_we", 64'(in_ready_o), 64'(we_o == 2'b00));
      if (we_o != 2'b00) begin
        chk("strm_latency", 64'(idx), 64'(2 + 4 * (nw + 1)));
        chk("strm_we", 64'(we_o), 64'(2'b01));
        chk("strm_addr", 64'(write_addr_o), 64'(nw));
        chk("strm_data", 64'(data_o), 64'(32'h13121110 + 32'(nw) * 32'h04040404));
        nw++;
      end
    end
    chk("strm_words", 64'(nw), 64'(3));
    chk("strm_ready_low", 64'(lowc), 64'(3));
    step(1'b0, 8'h00, 1'b0);
    chk("strm_done", 64'({busy_o, write_addr_o, word_cnt_o}), 64'({1'b0, 10'h003, 16'd3}));

    // Async reset mid-DATA with err set.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    chk("pre_reset", 64'({busy_o, err_o}), 64'({1'b1, 1'b1}));
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("async_reset", 64'(outs()), 64'({2'b00, 10'h000, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0}));
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);
    chk("post_reset_write", 64'(outs()),
        64'({2'b01, 10'h000, 32'hD4C3B2A1, 1'b1, 1'b0, 1'b0, 16'd0}));
    step(1'b0, 8'h00, 1'b0);
    chk("post_reset_idle", 64'({we_o, busy_o, write_addr_o, word_cnt_o}),
        64'({2'b00, 1'b0, 10'h001, 16'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
